// File: rtl/hw3proc_ledr_fader.sv
// hw3proc_ledr_fader
//   LED fader placed between the LEDR PIO out_port and the LEDR pins.
//   Each LED has a brightness level that ramps one step per fade tick
//   toward its target (0 or LMAX). The level is rendered as PWM against a
//   free-running counter, so level 0 is always off and LMAX is always on.
//
//   Optional feature (compile-time macro LEDR_FADE_SNAP_EN):
//     Adds an input `snap`. While snap is high, every level jumps straight to
//     its target level on each clock, overriding the fade tick.
//     Without the macro the port does not exist and levels move only on ticks.
module hw3proc_ledr_fader #(
    parameter int WIDTH      = 18,
    parameter int LEVEL_BITS = 4,
    parameter int TICK_DIV   = 250000
) (
    input  logic             clk,
    input  logic             reset,
`ifdef LEDR_FADE_SNAP_EN
    input  logic             snap,
`endif
    input  logic [WIDTH-1:0] pattern_in,
    output logic [WIDTH-1:0] ledr,
    output logic             busy
);

    // TICK_DIV >= 2, so at least one prescaler bit is needed.
    localparam int PRESC_W = $clog2(TICK_DIV);

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [LEVEL_BITS-1:0] LMAX       = LEVEL_BITS'(2**LEVEL_BITS - 1);
    // PWM counter period is LMAX cycles, so that level LMAX gives 100% duty.
    localparam logic [LEVEL_BITS-1:0] PWM_LAST   = LEVEL_BITS'(2**LEVEL_BITS - 2);

    // Saturating one-step move toward 0 (up=0) or LMAX (up=1); never wraps.
    function automatic logic [LEVEL_BITS-1:0] fade_step(
        input logic [LEVEL_BITS-1:0] lvl,
        input logic                  up
    );
        logic [LEVEL_BITS-1:0] res;
        res = lvl;
        if (up) begin
            if (lvl != LMAX) begin
                res = lvl + 1'b1;
            end
        end else begin
            if (lvl != '0) begin
                res = lvl - 1'b1;
            end
        end
        return res;
    endfunction

    // Brightness level an LED settles at for a given target bit.
    function automatic logic [LEVEL_BITS-1:0] target_level(input logic on);
        return on ? LMAX : '0;
    endfunction

    logic [WIDTH-1:0]                 target_q, target_d;
    logic [PRESC_W-1:0]               presc_q,  presc_d;
    logic [LEVEL_BITS-1:0]            pwm_q,    pwm_d;
    logic [WIDTH-1:0][LEVEL_BITS-1:0] level_q,  level_d;
    logic [WIDTH-1:0]                 ledr_q,   ledr_d;
    logic                             tick;
    logic                             snap_w;
    logic                             busy_w;

`ifdef LEDR_FADE_SNAP_EN
    assign snap_w = snap;
`else
    assign snap_w = 1'b0;
`endif

    // Fade tick: one cycle per prescaler period, on its last count.
    assign tick = (presc_q == PRESC_LAST);

    // Free-running counters: fade prescaler and PWM phase.
    always_comb begin
        target_d = pattern_in;
        presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        pwm_d    = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
    end

    // Per-LED level update: snap overrides, otherwise one step per tick.
    // The step uses the already-registered target, so a pattern change in the
    // tick cycle only takes effect on the following tick.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (snap_w) begin
                level_d[i] = target_level(target_q[i]);
            end else if (tick) begin
                level_d[i] = fade_step(level_q[i], target_q[i]);
            end
        end
    end

    // PWM compare: LED lit while its level exceeds the PWM phase.
    always_comb begin
        ledr_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ledr_d[i] = (level_q[i] > pwm_q);
        end
    end

    // busy: any LED not yet at the level its current target calls for.
    always_comb begin
        busy_w = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (level_q[i] != target_level(target_q[i])) begin
                busy_w = 1'b1;
            end
        end
    end

    // State registers; reset clears everything, aborting any ramp in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= '0;
            presc_q  <= '0;
            pwm_q    <= '0;
            level_q  <= '0;
            ledr_q   <= '0;
        end else begin
            target_q <= target_d;
            presc_q  <= presc_d;
            pwm_q    <= pwm_d;
            level_q  <= level_d;
            ledr_q   <= ledr_d;
        end
    end

    assign ledr = ledr_q;
    assign busy = busy_w;

endmodule

// File: tb/tb_hw3proc_ledr_fader.sv
// Directed bench for hw3proc_ledr_fader with TICK_DIV=4 (LMAX=15).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// After a reset release, posedge n (counting from 1) carries fade ticks when
// n is a multiple of 4, so level = n/4 while ramping up from 0.
module tb_hw3proc_ledr_fader;

    logic        clk = 1'b0;
    logic        reset;
    logic        snap;
    logic [17:0] pattern_in;
    logic [17:0] ledr;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cnt;

    hw3proc_ledr_fader #(
        .WIDTH      (18),
        .LEVEL_BITS (4),
        .TICK_DIV   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef LEDR_FADE_SNAP_EN
        .snap       (snap),
`endif
        .pattern_in (pattern_in),
        .ledr       (ledr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [17:0] p);
        reset      = 1'b1;
        pattern_in = p;
        cyc(2);
        reset      = 1'b0;
    endtask

    task automatic count_led0(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (ledr[0] === 1'b1) c++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        snap       = 1'b0;
        pattern_in = 18'h3FFFF;

        // 1: reset held 3 cycles with all targets on
        cyc(3);
        check("rst_ledr", 32'(ledr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        cyc(1);
        check("rel_busy", 32'(busy), 32'h1);

        // 2: ramp up LED 0
        do_reset(18'h00001);
        cyc(1);
        check("up_lvl_p1", 32'(dut.level_q[0]), 32'd0);
        check("up_busy_p1", 32'(busy), 32'h1);
        cyc(3);
        check("up_lvl_p4", 32'(dut.level_q[0]), 32'd1);
        cyc(4);
        check("up_lvl_p8", 32'(dut.level_q[0]), 32'd2);
        cyc(52);
        check("up_lvl_p60", 32'(dut.level_q[0]), 32'd15);
        check("up_busy_p60", 32'(busy), 32'h0);
        cyc(8);
        check("up_sat_p68", 32'(dut.level_q[0]), 32'd15);
        count_led0(15, cnt);
        check("up_duty15", 32'(cnt), 32'd15);
        check("up_others", 32'(ledr[17:1]), 32'h0);

        // 3: duty at frozen level 5
        do_reset(18'h00001);
        cyc(20);
        check("duty_lvl5", 32'(dut.level_q[0]), 32'd5);
        force dut.tick = 1'b0;
        pattern_in = 18'h00000;
        cyc(2);
        check("duty_busy", 32'(busy), 32'h1);
        count_led0(15, cnt);
        check("duty5_of15", 32'(cnt), 32'd5);
        check("duty_hold", 32'(dut.level_q[0]), 32'd5);
        release dut.tick;

        // 4: reversal at level 8
        do_reset(18'h00001);
        cyc(32);
        check("rev_lvl8", 32'(dut.level_q[0]), 32'd8);
        pattern_in = 18'h00000;
        cyc(4);
        check("rev_lvl7", 32'(dut.level_q[0]), 32'd7);
        cyc(24);
        check("rev_lvl1", 32'(dut.level_q[0]), 32'd1);
        check("rev_busy1", 32'(busy), 32'h1);
        cyc(4);
        check("rev_lvl0", 32'(dut.level_q[0]), 32'd0);
        check("rev_busy0", 32'(busy), 32'h0);
        cyc(2);
        count_led0(15, cnt);
        check("rev_duty0", 32'(cnt), 32'd0);
        check("rev_floor", 32'(dut.level_q[0]), 32'd0);

        // 5: reset in the middle of a fade
        do_reset(18'h20001);
        cyc(40);
        check("mid_lvl0_10", 32'(dut.level_q[0]), 32'd10);
        check("mid_lvl17_10", 32'(dut.level_q[17]), 32'd10);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_lvl0", 32'(dut.level_q[0]), 32'd0);
        check("mid_rst_lvl17", 32'(dut.level_q[17]), 32'd0);
        check("mid_rst_ledr", 32'(ledr), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        cyc(4);
        check("mid_restart0", 32'(dut.level_q[0]), 32'd1);
        check("mid_restart17", 32'(dut.level_q[17]), 32'd1);
        check("mid_restart_busy", 32'(busy), 32'h1);

`ifdef LEDR_FADE_SNAP_EN
        // 6: snap straight to target
        do_reset(18'h2AAAA);
        cyc(1);
        snap = 1'b1;
        cyc(1);
        snap = 1'b0;
        check("snap_lvl1", 32'(dut.level_q[1]), 32'd15);
        check("snap_lvl17", 32'(dut.level_q[17]), 32'd15);
        check("snap_lvl0", 32'(dut.level_q[0]), 32'd0);
        check("snap_lvl16", 32'(dut.level_q[16]), 32'd0);
        check("snap_busy", 32'(busy), 32'h0);
        cyc(1);
        check("snap_ledr", 32'(ledr), 32'h2AAAA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
